// File: rtl/pool_seq_ctrl.sv
// pool_seq_ctrl: frame sequencer for the 2x2 max-pool/ReLU stage.
// Clears the pool stage before each frame, gates the conv valid stream into it,
// tracks the input column/row, counts pooled outputs, pulses frame_done at frame
// completion and keeps sticky protocol error flags.
// Optional build macro POOL_PERF_CNT_EN adds the perf_cycles/perf_stall counters.
module pool_seq_ctrl #(
  parameter int IN_WIDTH      = 24,
  parameter int IN_HEIGHT     = 24,
  parameter int COL_BIT       = 5,
  parameter int ROW_BIT       = 5,
  parameter int OUT_CNT_BIT   = 8,
  parameter int DRAIN_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   conv_valid,
  input  logic                   pool_valid_out,
  input  logic                   err_clr,
  output logic                   pool_rst_n,
  output logic                   pool_valid_in,
  output logic                   busy,
  output logic [COL_BIT-1:0]     col,
  output logic [ROW_BIT-1:0]     row,
  output logic [OUT_CNT_BIT-1:0] out_cnt,
  output logic                   frame_done,
  output logic [3:0]             err
`ifdef POOL_PERF_CNT_EN
  , output logic [15:0]          perf_cycles
  , output logic [15:0]          perf_stall
`endif
);

  localparam int OUT_TOTAL = (IN_WIDTH / 2) * (IN_HEIGHT / 2);
  localparam int TMR_BIT   = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [OUT_CNT_BIT-1:0] OUT_TOTAL_V = OUT_CNT_BIT'(OUT_TOTAL);
  localparam logic [COL_BIT-1:0]     COL_LAST    = COL_BIT'(IN_WIDTH - 1);
  localparam logic [ROW_BIT-1:0]     ROW_LAST    = ROW_BIT'(IN_HEIGHT - 1);
  localparam logic [TMR_BIT-1:0]     TMR_LAST    = TMR_BIT'(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {IDLE, CLEAR, ACTIVE, DRAIN, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [TMR_BIT-1:0]     drain_tmr;
  logic [OUT_CNT_BIT-1:0] out_cnt_nxt;
  logic                   accept;
  logic                   last_pix;
  logic                   cnt_full;
  logic                   drain_full;
  logic                   drain_expire;
  logic [3:0]             err_set;

  assign accept       = (state == ACTIVE) && conv_valid;
  assign last_pix     = accept && (col == COL_LAST) && (row == ROW_LAST);
  assign cnt_full     = (out_cnt == OUT_TOTAL_V);
  assign drain_full   = (out_cnt_nxt == OUT_TOTAL_V);
  assign drain_expire = ((drain_tmr + 1'b1) == TMR_LAST);

  // State register; synchronous reset drops any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: the drain exit looks at the post-increment count so a pool
  // output arriving in the first DRAIN cycle finishes the frame immediately.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = ACTIVE;
      ACTIVE:  if (last_pix) state_nxt = DRAIN;
      DRAIN:   if (drain_full || drain_expire) state_nxt = DONE;
      DONE:    state_nxt = start ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode plus the per-cycle error set vector.
  always_comb begin
    busy          = (state == CLEAR) || (state == ACTIVE) || (state == DRAIN);
    pool_valid_in = accept;
    frame_done    = (state == DONE);
    err_set       = '0;
    err_set[0]    = conv_valid && (state != ACTIVE);
    err_set[1]    = start && busy;
    err_set[2]    = (state == DRAIN) && !drain_full && drain_expire;
    err_set[3]    = pool_valid_out &&
                    ((state == IDLE) || (state == CLEAR) || (state == DONE) || cnt_full);
  end

  // Pool clear is registered from the next state so it lines up with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) pool_rst_n <= 1'b0;
    else        pool_rst_n <= (state_nxt == ACTIVE) || (state_nxt == DRAIN) || (state_nxt == DONE);
  end

  // Pooled-output count: cleared in CLEAR, saturating at the frame total.
  always_comb begin
    out_cnt_nxt = out_cnt;
    if (state == CLEAR)
      out_cnt_nxt = '0;
    else if (((state == ACTIVE) || (state == DRAIN)) && pool_valid_out && !cnt_full)
      out_cnt_nxt = out_cnt + 1'b1;
  end

  // Counter registers; col/row/out_cnt hold after the frame until the next CLEAR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      out_cnt   <= '0;
      drain_tmr <= '0;
    end else begin
      out_cnt <= out_cnt_nxt;
      if (state == CLEAR) begin
        col       <= '0;
        row       <= '0;
        drain_tmr <= '0;
      end else begin
        if (accept) begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        if (state == DRAIN) drain_tmr <= drain_tmr + 1'b1;
      end
    end
  end

  // Sticky errors; a new set in the same cycle as err_clr wins for that bit.
  always_ff @(posedge clk) begin
    if (!rst_n) err <= '0;
    else        err <= (err & {4{~err_clr}}) | err_set;
  end

`ifdef POOL_PERF_CNT_EN
  // Frame cycle and stall counters, saturating, cleared in CLEAR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == CLEAR) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (((state == ACTIVE) || (state == DRAIN)) && (perf_cycles != 16'hFFFF))
        perf_cycles <= perf_cycles + 1'b1;
      if ((state == ACTIVE) && !conv_valid && (perf_stall != 16'hFFFF))
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// tb_pool_seq_ctrl: directed frames against a count-based behavioural model of
// the pool sequencer, compared every cycle, plus hand-computed spot checks.
// Build with POOL_PERF_CNT_EN to cover the perf counters as well.
module tb_pool_seq_ctrl;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int TOTAL = (W / 2) * (H / 2);
  localparam int TMO   = 4;

  localparam int PH_IDLE   = 0;
  localparam int PH_CLEAR  = 1;
  localparam int PH_ACTIVE = 2;
  localparam int PH_DRAIN  = 3;
  localparam int PH_DONE   = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       conv_valid;
  logic       pool_valid_out;
  logic       err_clr;
  logic       pool_rst_n;
  logic       pool_valid_in;
  logic       busy;
  logic [4:0] col;
  logic [4:0] row;
  logic [7:0] out_cnt;
  logic       frame_done;
  logic [3:0] err;
`ifdef POOL_PERF_CNT_EN
  logic [15:0] perf_cycles;
  logic [15:0] perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model state: phase, accepted pixels, pool outputs, drain cycles.
  int       m_ph;
  int       m_acc;
  int       m_outs;
  int       m_drain;
  int       m_pc;
  int       m_ps;
  logic [3:0] m_err;

  pool_seq_ctrl #(
    .IN_WIDTH(W), .IN_HEIGHT(H), .COL_BIT(5), .ROW_BIT(5),
    .OUT_CNT_BIT(8), .DRAIN_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .conv_valid(conv_valid),
    .pool_valid_out(pool_valid_out), .err_clr(err_clr),
    .pool_rst_n(pool_rst_n), .pool_valid_in(pool_valid_in), .busy(busy),
    .col(col), .row(row), .out_cnt(out_cnt), .frame_done(frame_done), .err(err)
`ifdef POOL_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int outsAfter(int ph, int outs, bit pv);
    if (ph == PH_CLEAR) return 0;
    if ((ph == PH_ACTIVE || ph == PH_DRAIN) && pv && outs < TOTAL) return outs + 1;
    return outs;
  endfunction

  function automatic logic [3:0] errSet(int ph, bit st, bit cv, bit pv, int outs, int drain);
    logic [3:0] e;
    e    = '0;
    e[0] = cv && (ph != PH_ACTIVE);
    e[1] = st && (ph == PH_CLEAR || ph == PH_ACTIVE || ph == PH_DRAIN);
    e[2] = (ph == PH_DRAIN) && (outsAfter(ph, outs, pv) != TOTAL) && (drain + 1 >= TMO);
    e[3] = pv && (ph == PH_IDLE || ph == PH_CLEAR || ph == PH_DONE || outs >= TOTAL);
    return e;
  endfunction

  function automatic int phaseNext(int ph, bit st, bit cv, int acc, int outs_after, int drain);
    case (ph)
      PH_IDLE:   return st ? PH_CLEAR : PH_IDLE;
      PH_CLEAR:  return PH_ACTIVE;
      PH_ACTIVE: return (cv && acc + 1 == W * H) ? PH_DRAIN : PH_ACTIVE;
      PH_DRAIN:  return (outs_after == TOTAL || drain + 1 == TMO) ? PH_DONE : PH_DRAIN;
      default:   return st ? PH_CLEAR : PH_IDLE;
    endcase
  endfunction

  // Model update on each rising edge from the inputs presented in that cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph <= PH_IDLE; m_acc <= 0; m_outs <= 0; m_drain <= 0;
      m_pc <= 0; m_ps <= 0; m_err <= '0;
    end else begin
      m_ph    <= phaseNext(m_ph, start, conv_valid, m_acc,
                           outsAfter(m_ph, m_outs, pool_valid_out), m_drain);
      m_acc   <= (m_ph == PH_CLEAR) ? 0 : ((m_ph == PH_ACTIVE && conv_valid) ? m_acc + 1 : m_acc);
      m_outs  <= outsAfter(m_ph, m_outs, pool_valid_out);
      m_drain <= (m_ph == PH_CLEAR) ? 0 : ((m_ph == PH_DRAIN) ? m_drain + 1 : m_drain);
      m_err   <= (err_clr ? 4'b0000 : m_err) |
                 errSet(m_ph, start, conv_valid, pool_valid_out, m_outs, m_drain);
      m_pc    <= (m_ph == PH_CLEAR) ? 0 :
                 (((m_ph == PH_ACTIVE || m_ph == PH_DRAIN) && m_pc < 65535) ? m_pc + 1 : m_pc);
      m_ps    <= (m_ph == PH_CLEAR) ? 0 :
                 ((m_ph == PH_ACTIVE && !conv_valid && m_ps < 65535) ? m_ps + 1 : m_ps);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("m_pool_rst_n", int'(pool_rst_n),
                int'(m_ph == PH_ACTIVE || m_ph == PH_DRAIN || m_ph == PH_DONE));
    checkOutput("m_busy", int'(busy),
                int'(m_ph == PH_CLEAR || m_ph == PH_ACTIVE || m_ph == PH_DRAIN));
    checkOutput("m_pool_valid_in", int'(pool_valid_in), int'(m_ph == PH_ACTIVE && conv_valid));
    checkOutput("m_frame_done", int'(frame_done), int'(m_ph == PH_DONE));
    checkOutput("m_col", int'(col), m_acc % W);
    checkOutput("m_row", int'(row), m_acc / W);
    checkOutput("m_out_cnt", int'(out_cnt), m_outs);
    checkOutput("m_err", int'(err), int'(m_err));
`ifdef POOL_PERF_CNT_EN
    checkOutput("m_perf_cycles", int'(perf_cycles), m_pc);
    checkOutput("m_perf_stall", int'(perf_stall), m_ps);
`endif
  endtask

  // One cycle: drive inputs after the edge, compare at mid-cycle, step past the edge.
  task automatic applyStimulus(input bit st, input bit cv, input bit pv, input bit ec);
    start = st; conv_valid = cv; pool_valid_out = pv; err_clr = ec;
    @(negedge clk);
    compareModel();
    @(posedge clk);
    #1;
  endtask

  task automatic resetCycle();
    rst_n = 1'b0; start = 0; conv_valid = 0; pool_valid_out = 0; err_clr = 0;
    @(negedge clk);
    compareModel();
    @(posedge clk);
    #1;
    checkOutput("rst_col", int'(col), 0);
    checkOutput("rst_row", int'(row), 0);
    checkOutput("rst_out_cnt", int'(out_cnt), 0);
    checkOutput("rst_pool_rst_n", int'(pool_rst_n), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_err", int'(err), 0);
    rst_n = 1'b1;
  endtask

  // Full frame from IDLE or DONE; pool answers one cycle after inputs 6, 8, 14, 16.
  // mode 0: continuous, 1: every other cycle, 2: stall on cycles 1, 6, 11, 16.
  task automatic runFrame(input int mode, input int start_at, input bit withhold,
                          input int abort_at, input bit drain_poke);
    int acc;
    int cyc;
    bit pend;
    bit cv;
    bit st;
    bit st_done;
    acc = 0; cyc = 0; pend = 0; st_done = 0;
    applyStimulus(1, 0, 0, 0);
    checkOutput("clear_pool_rst_n", int'(pool_rst_n), 0);
    checkOutput("clear_busy", int'(busy), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("active_pool_rst_n", int'(pool_rst_n), 1);
    while (acc < W * H) begin
      case (mode)
        1:       cv = (cyc % 2 == 0);
        2:       cv = (cyc % 5 != 1);
        default: cv = 1'b1;
      endcase
      st = (acc == start_at) && !st_done;
      if (st) st_done = 1'b1;
      applyStimulus(st, cv, pend, 0);
      pend = cv && (acc + 1 == 6 || acc + 1 == 8 || acc + 1 == 14 || acc + 1 == 16);
      if (cv) acc++;
      cyc++;
      if (abort_at > 0 && acc == abort_at) begin
        resetCycle();
        return;
      end
    end
    applyStimulus(0, drain_poke, pend && !withhold, 0);
    if (withhold) repeat (TMO - 1) applyStimulus(0, 0, 0, 0);
    checkOutput("frame_done_pulse", int'(frame_done), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 0; conv_valid = 0; pool_valid_out = 0; err_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_pool_rst_n", int'(pool_rst_n), 0);
    checkOutput("init_col", int'(col), 0);
    checkOutput("init_out_cnt", int'(out_cnt), 0);
    checkOutput("init_frame_done", int'(frame_done), 0);
    checkOutput("init_err", int'(err), 0);
    rst_n = 1'b1;

    $display("[TB] frame with continuous input");
    runFrame(0, -1, 0, -1, 0);
    checkOutput("t1_out_cnt", int'(out_cnt), 4);
    checkOutput("t1_err", int'(err), 0);
    checkOutput("t1_row_end", int'(row), 4);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t1_done_one_cycle", int'(frame_done), 0);
    checkOutput("t1_out_cnt_hold", int'(out_cnt), 4);

    $display("[TB] frame with toggling input, then back-to-back frame");
    runFrame(1, -1, 0, -1, 0);
    checkOutput("t2_out_cnt", int'(out_cnt), 4);
    checkOutput("t2_err", int'(err), 0);
    runFrame(0, -1, 0, -1, 0);
    checkOutput("t2b_out_cnt", int'(out_cnt), 4);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] dropped input and err_clr");
    applyStimulus(0, 1, 0, 0);
    checkOutput("t3_drop_idle", int'(err), 4'b0001);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t3_clr", int'(err), 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("t3_clr_vs_set", int'(err), 4'b0001);
    applyStimulus(0, 0, 0, 1);
    runFrame(0, -1, 0, -1, 1);
    checkOutput("t3_drop_drain", int'(err), 4'b0001);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] start while busy, drain timeout, spurious pool output");
    runFrame(0, 5, 0, -1, 0);
    checkOutput("t4_start_busy", int'(err), 4'b0010);
    applyStimulus(0, 0, 0, 1);
    runFrame(0, -1, 1, -1, 0);
    checkOutput("t4_timeout_err", int'(err), 4'b0100);
    checkOutput("t4_timeout_cnt", int'(out_cnt), 3);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t4_spurious", int'(err), 4'b1100);
    applyStimulus(0, 1, 0, 1);
    checkOutput("t4_clr_set_wins", int'(err), 4'b0001);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] reset mid-frame then full frame");
    runFrame(0, -1, 0, 9, 0);
    runFrame(0, -1, 0, -1, 0);
    checkOutput("t5_out_cnt", int'(out_cnt), 4);
    checkOutput("t5_err", int'(err), 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] frame with four stall cycles");
    runFrame(2, -1, 0, -1, 0);
    checkOutput("t6_out_cnt", int'(out_cnt), 4);
`ifdef POOL_PERF_CNT_EN
    checkOutput("t6_perf_stall", int'(perf_stall), 4);
    checkOutput("t6_perf_cycles", int'(perf_cycles), 21);
`endif
    repeat (2) applyStimulus(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
